breath_key_ctrl: RTL
====================

BREATH_KEY_CTRL -- requirements
Module: breath_key_ctrl

Interface
REQ-001 The block SHALL take parameter CNT_MAX, default 999_999, as the debounce length in clk cycles (20 ms at 50 MHz).
REQ-002 The block SHALL take parameter LONG_MAX, default 99_999_999, as the long-press length in clk cycles (2 s at 50 MHz); LONG_MAX > CNT_MAX is required.
REQ-003 clk  input  1  system clock, 50 MHz; the only clock in the block.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 key_in  input  1  raw push-button input, active-low, asynchronous to clk, bouncy.
REQ-006 key_flag  output  1  one-cycle pulse on each accepted short press.
REQ-007 long_flag  output  1  one-cycle pulse on each accepted long press.
REQ-008 breath_en  output  1  enable for the downstream breathing-LED stage; high in any non-OFF mode.
REQ-009 speed_sel  output  2  breathing speed for the downstream stage: 00 off, 01 slow, 10 mid, 11 fast.

Function
REQ-010 key_in SHALL pass through a two-flop synchronizer (key_s1, key_s2) before any other use; both flops SHALL reset to 1.
REQ-011 Debounce counter cnt SHALL be sized to hold LONG_MAX.
REQ-012 cnt SHALL increment on each edge where key_s2 is 0, and SHALL saturate at LONG_MAX.
REQ-013 Any edge with key_s2 equal to 1 SHALL clear cnt to 0 (bounce or release).
REQ-014 key_flag SHALL be registered high for exactly the one cycle following the edge at which cnt goes from CNT_MAX-1 to CNT_MAX.
REQ-015 long_flag SHALL be registered high for exactly the one cycle following the edge at which cnt goes from LONG_MAX-1 to LONG_MAX.
REQ-016 Latency: with key_in first sampled low at edge k and held stable low, key_flag SHALL be high in the cycle after edge k+1+CNT_MAX.
REQ-017 A held key SHALL produce at most one key_flag and one long_flag; a new press requires key_s2 to return to 1 first.
REQ-018 A press whose low time is shorter than CNT_MAX synchronized cycles SHALL produce no flag.
REQ-019 Mode FSM states SHALL be OFF, SLOW, MID, FAST.
REQ-020 On key_flag the FSM SHALL advance OFF->SLOW->MID->FAST->OFF (wrap).
REQ-021 On long_flag the FSM SHALL go to OFF from any state; key_flag and long_flag never coincide because LONG_MAX > CNT_MAX.
REQ-022 A long press SHALL first advance the FSM once (at key_flag), then force OFF (at long_flag).
REQ-023 The FSM state SHALL update on the edge ending the flag cycle.
REQ-024 breath_en and speed_sel SHALL be registered decodes of the state: OFF=0/00, SLOW=1/01, MID=1/10, FAST=1/11.
REQ-025 breath_en and speed_sel SHALL change in the same cycle as each other, one cycle after the state change.
REQ-026 All outputs SHALL be glitch-free register outputs.

Reset
REQ-027 While rst_n is 0 at an edge: key_s1=key_s2=1, cnt=0, key_flag=0, long_flag=0, state=OFF, breath_en=0, speed_sel=00.
REQ-028 A reset asserted mid-press SHALL discard the partial count.
REQ-029 A key held low through reset release SHALL be treated as a new press and SHALL need a full CNT_MAX stable-low count before key_flag.
REQ-030 A reset asserted in the same cycle as a flag SHALL win: no state advance.

Verification (bench with CNT_MAX=4, LONG_MAX=20, 20 ns clk, rst_n low 100 ns)
REQ-031 Reset: rst_n=0 for 5 cycles with key_in=0 -> all outputs 0 / 00 throughout; no flag until 4 stable-low cycles after release.
REQ-032 Clean short press: key_in low 10 cycles -> one key_flag pulse 6 cycles after first low sample; speed_sel 00->01 and breath_en 0->1; no long_flag.
REQ-033 Bounce: key_in toggles low 3 / high 1 / low 2 / high 1, then low 8 -> exactly one key_flag, timed from the start of the final stable-low run.
REQ-034 Four short presses separated by 5 high cycles -> speed_sel sequence 01, 10, 11, 00; breath_en 1,1,1,0.
REQ-035 Long press from MID: key_in low 30 cycles -> key_flag (MID->FAST), then long_flag 16 cycles later -> OFF, speed_sel 00, breath_en 0; no further flags while held.
REQ-036 Reset mid-press: rst_n pulsed low at cnt=3 -> no key_flag from the partial count; state stays OFF.

Source files
------------

// File: rtl/breath_key_ctrl.sv
// -----------------------------------------------------------------------------
// breath_key_ctrl
//
// Push-button front end for a breathing-LED stage. The raw, bouncy, active-low
// key is synchronized, debounced with a single saturating counter, and turned
// into two pulses: key_flag (short press accepted after CNT_MAX stable-low
// cycles) and long_flag (long press accepted after LONG_MAX stable-low cycles).
// A 4-state mode FSM steps OFF->SLOW->MID->FAST->OFF on key_flag and drops to
// OFF on long_flag. The mode is decoded into registered enable/speed outputs.
//
// Ports
//   clk        in   system clock (only clock in the block)
//   rst_n      in   synchronous active-low reset
//   key_in     in   raw push-button, active-low, asynchronous to clk
//   key_flag   out  one-cycle pulse per accepted short press
//   long_flag  out  one-cycle pulse per accepted long press
//   breath_en  out  high whenever the mode is not OFF
//   speed_sel  out  00 off, 01 slow, 10 mid, 11 fast
// -----------------------------------------------------------------------------
module breath_key_ctrl #(
    parameter int unsigned CNT_MAX  = 999_999,
    parameter int unsigned LONG_MAX = 99_999_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_flag,
    output logic       long_flag,
    output logic       breath_en,
    output logic [1:0] speed_sel
);

    localparam int unsigned CW = $clog2(LONG_MAX + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MAX - 1);
    localparam logic [CW-1:0] LONG_TOP  = CW'(LONG_MAX);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SLOW = 2'd1,
        ST_MID  = 2'd2,
        ST_FAST = 2'd3
    } state_t;

    logic          key_s1_q, key_s1_d;
    logic          key_s2_q, key_s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_flag_q, key_flag_d;
    logic          long_flag_q, long_flag_d;
    state_t        state_q, state_d;
    logic          breath_en_q, breath_en_d;
    logic [1:0]    speed_sel_q, speed_sel_d;

    // Synchronizer and debounce counter. The counter saturates at LONG_MAX so
    // each threshold is crossed exactly once per held press; any high sample
    // (bounce or release) restarts the count from zero.
    always_comb begin
        key_s1_d    = key_in;
        key_s2_d    = key_s1_q;
        cnt_d       = '0;
        key_flag_d  = 1'b0;
        long_flag_d = 1'b0;
        if (!key_s2_q) begin
            cnt_d       = (cnt_q == LONG_TOP) ? cnt_q : cnt_q + CW'(1);
            key_flag_d  = (cnt_q == CNT_LAST);
            long_flag_d = (cnt_q == LONG_LAST);
        end
    end

    // Mode FSM next-state. key_flag and long_flag cannot be high together
    // since the long threshold lies strictly above the short one.
    always_comb begin
        state_d = state_q;
        if (key_flag_q) begin
            case (state_q)
                ST_OFF:  state_d = ST_SLOW;
                ST_SLOW: state_d = ST_MID;
                ST_MID:  state_d = ST_FAST;
                ST_FAST: state_d = ST_OFF;
                default: state_d = ST_OFF;
            endcase
        end else if (long_flag_q) begin
            state_d = ST_OFF;
        end
    end

    // Output decode, registered one cycle behind the state.
    always_comb begin
        breath_en_d = (state_q != ST_OFF);
        speed_sel_d = 2'b00;
        case (state_q)
            ST_OFF:  speed_sel_d = 2'b00;
            ST_SLOW: speed_sel_d = 2'b01;
            ST_MID:  speed_sel_d = 2'b10;
            ST_FAST: speed_sel_d = 2'b11;
            default: speed_sel_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_s1_q    <= 1'b1;
            key_s2_q    <= 1'b1;
            cnt_q       <= '0;
            key_flag_q  <= 1'b0;
            long_flag_q <= 1'b0;
            breath_en_q <= 1'b0;
            speed_sel_q <= 2'b00;
        end else begin
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            cnt_q       <= cnt_d;
            key_flag_q  <= key_flag_d;
            long_flag_q <= long_flag_d;
            breath_en_q <= breath_en_d;
            speed_sel_q <= speed_sel_d;
        end
    end

    assign key_flag  = key_flag_q;
    assign long_flag = long_flag_q;
    assign breath_en = breath_en_q;
    assign speed_sel = speed_sel_q;

endmodule
